spi_master_ctrl: RTL

Parametrised SPI master clocked from the system clock, successor to the SCLK-clocked SPI driver. Generates SCLK internally with a clock divider and supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, variable transfer lengths up to SPI_MAXLEN, and NUM_CS independent slave selects. It sits between a register or command front-end and the board SPI pins. Each accepted command becomes one framed transaction, and the received word is returned with a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_clk_gen.sv | 29 ++
 rtl/spi_master_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and width helpers for the system-clocked SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Width of n_clks and the bit counter; holds SPI_MAXLEN itself.
    function automatic int unsigned cnt_width(int unsigned maxlen);
        return $clog2(maxlen) + 1;
    endfunction

    function automatic int unsigned sel_width(int unsigned num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    function automatic int unsigned idx_width(int unsigned maxlen);
        return (maxlen > 1) ? $clog2(maxlen) : 1;
    endfunction

    // Data-word position of the cnt-th bit on the wire.
    function automatic int unsigned bit_index(int unsigned cnt, int unsigned n, logic lsb_first);
        return lsb_first ? cnt : (n - 1 - cnt);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle tick every HALF enabled cycles, cleared synchronously.
module spi_clk_gen #(
    parameter int unsigned HALF = 50
) (
    input  logic clk,
    input  logic sresetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(HALF) + 1;
    localparam logic [W-1:0] Last = W'(HALF - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + W'(1);
        end
    end

    assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master with internal SCLK divider, all CPOL/CPHA modes, MSB/LSB order and NUM_CS selects.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIVIDE = 100,
    parameter int unsigned SPI_MAXLEN = 16,
    parameter int unsigned NUM_CS     = 1
) (
    input  logic                              clk,
    input  logic                              sresetn,
    input  logic                              start_cmd,
    output logic                              spi_drv_rdy,
    input  logic [cnt_width(SPI_MAXLEN)-1:0]  n_clks,
    input  logic [SPI_MAXLEN-1:0]             tx_data,
    input  logic [sel_width(NUM_CS)-1:0]      cs_sel,
    input  logic                              cpol,
    input  logic                              cpha,
    input  logic                              lsb_first,
    output logic [SPI_MAXLEN-1:0]             rx_miso,
    output logic                              rx_valid,
    output logic                              SCLK,
    output logic                              MOSI,
    input  logic                              MISO,
    output logic [NUM_CS-1:0]                 SS_N
);

    localparam int unsigned H    = CLK_DIVIDE / 2;
    localparam int unsigned CntW = cnt_width(SPI_MAXLEN);
    localparam int unsigned IdxW = idx_width(SPI_MAXLEN);

    function automatic logic [IdxW-1:0] idx_of(logic [CntW-1:0] cnt, logic [CntW-1:0] n,
                                               logic lsb);
        return IdxW'(bit_index(32'(cnt), 32'(n), lsb));
    endfunction

    spi_state_t            state_q, state_d;
    spi_mode_t             mode_q, mode_d;
    logic [CntW-1:0]       n_q, n_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SPI_MAXLEN-1:0] tx_q, tx_d;
    logic [SPI_MAXLEN-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_MAXLEN-1:0] rx_miso_q, rx_miso_d;
    logic [NUM_CS-1:0]     ss_n_q, ss_n_d;
    logic                  trail_q, trail_d;  // next SCLK edge is the trailing one
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  rdy_q, rdy_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  cmd_ok, clr, tick, last_bit;

    spi_clk_gen #(
        .HALF(H)
    ) u_clk_gen (
        .clk    (clk),
        .sresetn(sresetn),
        .en     (state_q != IDLE),
        .clr    (clr),
        .tick   (tick)
    );

    assign cmd_ok = (n_clks != '0) && (32'(n_clks) <= SPI_MAXLEN) && (32'(cs_sel) < NUM_CS);
    assign last_bit = (bit_cnt_q == n_q - CntW'(1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_miso_d  = rx_miso_q;
        ss_n_d     = ss_n_q;
        trail_d    = trail_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rdy_d      = rdy_q;
        rx_valid_d = 1'b0;
        clr        = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (start_cmd && rdy_q && cmd_ok) begin
                    clr       = 1'b1;
                    state_d   = SETUP;
                    mode_d    = '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                    n_d       = n_clks;
                    tx_d      = tx_data;
                    bit_cnt_d = '0;
                    trail_d   = 1'b0;
                    rx_sh_d   = '0;
                    rdy_d     = 1'b0;
                    ss_n_d    = ~(NUM_CS'(1) << cs_sel);
                    mosi_d    = cpha ? 1'b0 : tx_data[idx_of('0, n_clks, lsb_first)];
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sclk_d  = ~sclk_q;
                    trail_d = ~trail_q;
                    if (!trail_q) begin
                        if (mode_q.cpha) begin
                            mosi_d = tx_q[idx_of(bit_cnt_q, n_q, mode_q.lsb_first)];
                        end else begin
                            rx_sh_d[idx_of(bit_cnt_q, n_q, mode_q.lsb_first)] = MISO;
                        end
                    end else begin
                        if (mode_q.cpha) begin
                            rx_sh_d[idx_of(bit_cnt_q, n_q, mode_q.lsb_first)] = MISO;
                        end
                        if (last_bit) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CntW'(1);
                            if (!mode_q.cpha) begin
                                mosi_d = tx_q[idx_of(bit_cnt_q + CntW'(1), n_q, mode_q.lsb_first)];
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d    = IDLE;
                    ss_n_d     = '1;
                    rdy_d      = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_miso_d  = rx_sh_q;
                    mosi_d     = 1'b0;
                    sclk_d     = mode_q.cpol;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            n_q        <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_miso_q  <= '0;
            ss_n_q     <= '1;
            trail_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rdy_q      <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_miso_q  <= rx_miso_d;
            ss_n_q     <= ss_n_d;
            trail_q    <= trail_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rdy_q      <= rdy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign spi_drv_rdy = rdy_q;
    assign rx_miso     = rx_miso_q;
    assign rx_valid    = rx_valid_q;
    assign SCLK        = sclk_q;
    assign MOSI        = mosi_q;
    assign SS_N        = ss_n_q;

endmodule
